exposure_combiner: RTL and testbench
====================================

Name: exposure_combiner

Overview:
- Downstream consumer of the camera sequencer's `shutter` output.
- Each camera frame has two shutter pulses. After each pulse the block accumulates a window of sensor pixel samples and averages both exposures into one result.
- It then raises `skip` back to the sequencer so the sequencer leaves PROCESS early.
- Sits between the sequencer/sensor interface and the downstream image pipeline.

Parameters:
- WIDTH, 8, pixel sample width in bits.
- LOG2_SAMPLES, 1, log2 of the samples accumulated per exposure window (2^LOG2_SAMPLES samples per exposure).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- shutter  input  1  shutter pulse from sequencer; one-cycle pulses, two per frame.
- pix_valid  input  1  sensor sample qualifier.
- pix_data  input  WIDTH  sensor sample, sampled only when pix_valid=1.
- skip  output  1  processing-done indication to sequencer (level).
- result_valid  output  1  one-cycle pulse, result/frame_err valid.
- result  output  WIDTH  averaged pixel value of the frame.
- frame_err  output  1  frame had an exposure overrun (qualified by result_valid).
- frame_count  output  8  number of completed frames, wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WAIT1.
  - sum=0, sample counter=0, err=0.
  - skip=0, result_valid=0, result=0, frame_err=0, frame_count=0.
- Definitions:
  - N = 2^LOG2_SAMPLES.
  - sum width = WIDTH+LOG2_SAMPLES+1, which cannot overflow for 2N samples.
  - All outputs are registered.
- States: WAIT1, EXP1, WAIT2, EXP2, DONE.
- WAIT1:
  - shutter=1 -> EXP1; clear sum, counter, err; clear skip.
  - pix_valid ignored.
- EXP1:
  - pix_valid=1 -> sum += pix_data (zero-extended), counter += 1.
  - When the N-th sample is accepted -> WAIT2 with counter=0. The sample accepted on that cycle is included in sum.
  - shutter=1 while in EXP1 (overrun) -> set err, go directly to EXP2 with counter=0. Partial sum is kept; pix_valid on that cycle is accepted into sum as the first EXP2 sample.
- WAIT2:
  - shutter=1 -> EXP2, counter=0.
  - pix_valid ignored.
- EXP2:
  - Accumulates exactly as EXP1.
  - N-th accepted sample -> DONE.
  - shutter=1 in EXP2 -> set err, otherwise ignored (no restart).
- DONE (one cycle):
  - result_valid=1, result = sum >> (LOG2_SAMPLES+1), truncating.
  - frame_err=err, frame_count += 1 (mod 256), skip set to 1.
  - Next state WAIT1. result/frame_err hold until the next DONE.
- skip:
  - Level; set in DONE, held until shutter=1 is sampled in WAIT1.
  - That clear takes effect the cycle after the shutter pulse.
  - Never asserted before the first completed frame.
- shutter sampled in DONE: ignored and does not start a frame; the sequencer guarantees ≥1 idle cycle between frames.
- Latency: result_valid asserts exactly 1 cycle after the cycle that accepts the final EXP2 sample.
- Reset mid-frame: returns to WAIT1 immediately, drops partial sum, clears skip and all outputs.

Test Plan:
- Basic frame (WIDTH=8, LOG2_SAMPLES=1): shutter pulse, pix_valid=1 with data 10,20; shutter pulse, data 30,40 -> one cycle later result_valid=1, result=25, frame_err=0, frame_count=1, skip=1.
- Rounding/extremes: all four samples 255 -> result=255 with no overflow; samples 1,0,0,0 -> result=0 (truncation).
- Gapped pix_valid: EXP1 samples 100,_,_,100 (valid low 2 cycles) and EXP2 samples 50,50 -> result=75; result_valid timing relative to the final accepted sample = 1 cycle.
- Overrun: shutter at t, one sample 80, second shutter at t+2 with pix_valid=1 data 80, then data 80 -> EXP2 complete; result=(80+80+80)>>2=60, frame_err=1.
- skip handshake: after DONE, skip stays 1 across idle cycles, then shutter pulse -> skip=0 on the next cycle; frame_count wraps from 255 to 0 after 256 frames.
- Reset mid-EXP2: assert reset asynchronously between clock edges -> all outputs 0 immediately; a following clean frame gives the correct result with frame_count=1.

Source files
------------

// File: rtl/exposure_combiner.sv
// exposure_combiner: averages two shutter-triggered exposure windows per frame.
// Each window accumulates 2^LOG2_SAMPLES qualified pixel samples. When the
// second window completes, the averaged result is published and skip is raised
// back to the sequencer.
// Ports:
//   clk, reset (async, active-low)
//   shutter             one-cycle shutter pulse, two per frame
//   pix_valid/pix_data  sensor sample stream
//   skip                level, processing done; cleared by the next frame's shutter
//   result_valid        one-cycle pulse qualifying result/frame_err
//   result              averaged pixel value of the frame
//   frame_err           frame saw an exposure overrun
//   frame_count         completed frames, wraps mod 256
module exposure_combiner #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned LOG2_SAMPLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shutter,
   input  logic             pix_valid,
   input  logic [WIDTH-1:0] pix_data,
   output logic             skip,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic             frame_err,
   output logic [7:0]       frame_count
);

   localparam int unsigned SUM_W = WIDTH + LOG2_SAMPLES + 1;
   localparam int unsigned CNT_W = LOG2_SAMPLES + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_SAMPLES) - 1);

   typedef enum logic [2:0] {
      WAIT1 = 3'd0,
      EXP1  = 3'd1,
      WAIT2 = 3'd2,
      EXP2  = 3'd3,
      DONE  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               skip_q, skip_d;
   logic               rv_q, rv_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               ferr_q, ferr_d;
   logic [7:0]         fcnt_q, fcnt_d;
   logic [SUM_W-1:0]   sum_acc;

   // Running sum including the current sample.
   assign sum_acc = sum_q + SUM_W'(pix_data);

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= WAIT1;
         sum_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         skip_q   <= 1'b0;
         rv_q     <= 1'b0;
         result_q <= '0;
         ferr_q   <= 1'b0;
         fcnt_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         skip_q   <= skip_d;
         rv_q     <= rv_d;
         result_q <= result_d;
         ferr_q   <= ferr_d;
         fcnt_q   <= fcnt_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      skip_d   = skip_q;
      rv_d     = 1'b0;
      result_d = result_q;
      ferr_d   = ferr_q;
      fcnt_d   = fcnt_q;

      case (state_q)
         WAIT1: begin
            if (shutter) begin
               state_d = EXP1;
               sum_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               skip_d  = 1'b0;
            end
         end
         EXP1: begin
            if (shutter) begin
               // Overrun: keep partial sum, this cycle's sample opens EXP2.
               state_d = EXP2;
               err_d   = 1'b1;
               cnt_d   = pix_valid ? CNT_W'(1) : '0;
               if (pix_valid) sum_d = sum_acc;
            end else if (pix_valid) begin
               sum_d = sum_acc;
               if (cnt_q == LAST_CNT) begin
                  state_d = WAIT2;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WAIT2: begin
            if (shutter) begin
               state_d = EXP2;
               cnt_d   = '0;
            end
         end
         EXP2: begin
            if (shutter) err_d = 1'b1;
            if (pix_valid) begin
               sum_d = sum_acc;
               if (cnt_q == LAST_CNT) begin
                  // Publish on the accepting edge so result_valid is high in DONE.
                  state_d  = DONE;
                  cnt_d    = '0;
                  rv_d     = 1'b1;
                  result_d = WIDTH'(sum_acc >> (LOG2_SAMPLES + 1));
                  ferr_d   = err_q | shutter;
                  fcnt_d   = fcnt_q + 8'd1;
                  skip_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            state_d = WAIT1;
         end
         default: begin
            state_d = WAIT1;
         end
      endcase
   end

   assign skip         = skip_q;
   assign result_valid = rv_q;
   assign result       = result_q;
   assign frame_err    = ferr_q;
   assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_exposure_combiner.sv
// Directed testbench for exposure_combiner (WIDTH=8, LOG2_SAMPLES=1).
module tb_exposure_combiner;

   logic       clk;
   logic       reset;
   logic       shutter;
   logic       pix_valid;
   logic [7:0] pix_data;
   logic       skip;
   logic       result_valid;
   logic [7:0] result;
   logic       frame_err;
   logic [7:0] frame_count;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   logic [7:0] exp_fc = 8'd0;

   exposure_combiner #(.WIDTH(8), .LOG2_SAMPLES(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .shutter      (shutter),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .skip         (skip),
      .result_valid (result_valid),
      .result       (result),
      .frame_err    (frame_err),
      .frame_count  (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply inputs for one clock, then sample 1 time unit after the edge.
   task automatic cyc(input logic sh, input logic pv, input logic [7:0] d);
      shutter   = sh;
      pix_valid = pv;
      pix_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Full frame: shutter, two samples, stray sample in WAIT2, shutter, two samples.
   task automatic frame(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] exp_res,
                        input logic do_chk);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, a0);
      cyc(1'b0, 1'b1, a1);
      cyc(1'b0, 1'b1, 8'd200);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, b0);
      if (do_chk) chk({tag, "_rv_early"}, 32'(result_valid), 32'd0);
      cyc(1'b0, 1'b1, b1);
      exp_fc = exp_fc + 8'd1;
      if (do_chk) begin
         chk({tag, "_rv"},     32'(result_valid), 32'd1);
         chk({tag, "_result"}, 32'(result),       32'(exp_res));
         chk({tag, "_err"},    32'(frame_err),    32'd0);
         chk({tag, "_count"},  32'(frame_count),  32'(exp_fc));
         chk({tag, "_skip"},   32'(skip),         32'd1);
      end
      cyc(1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      reset     = 1'b0;
      shutter   = 1'b0;
      pix_valid = 1'b0;
      pix_data  = 8'd0;
      #12;
      chk("rst_skip",   32'(skip),         32'd0);
      chk("rst_rv",     32'(result_valid), 32'd0);
      chk("rst_result", 32'(result),       32'd0);
      chk("rst_err",    32'(frame_err),    32'd0);
      chk("rst_count",  32'(frame_count),  32'd0);
      reset = 1'b1;
      #1;

      // Basic frame: (10+20+30+40)>>2 = 25
      frame("basic", 8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 1'b1);
      chk("basic_rv_pulse", 32'(result_valid), 32'd0);
      chk("basic_hold",     32'(result),       32'd25);

      // skip holds across idle cycles, clears the cycle after the shutter
      cyc(1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b0, 8'd0);
      chk("skip_hold", 32'(skip), 32'd1);
      cyc(1'b1, 1'b0, 8'd0);
      chk("skip_clear", 32'(skip), 32'd0);
      cyc(1'b0, 1'b1, 8'd1);
      cyc(1'b0, 1'b1, 8'd0);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd0);
      cyc(1'b0, 1'b1, 8'd0);
      exp_fc = exp_fc + 8'd1;
      chk("trunc_rv",     32'(result_valid), 32'd1);
      chk("trunc_result", 32'(result),       32'd0);
      cyc(1'b0, 1'b0, 8'd0);

      // Extremes: 4*255 = 1020, >>2 = 255
      frame("max", 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);

      // Gapped pix_valid: (100+100+50+50)>>2 = 75
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd100);
      cyc(1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd100);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd50);
      chk("gap_rv_early", 32'(result_valid), 32'd0);
      cyc(1'b0, 1'b1, 8'd50);
      exp_fc = exp_fc + 8'd1;
      chk("gap_rv",     32'(result_valid), 32'd1);
      chk("gap_result", 32'(result),       32'd75);
      // Shutter in DONE is ignored: no frame starts, skip stays set
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd99);
      chk("done_sh_skip", 32'(skip), 32'd1);
      cyc(1'b0, 1'b0, 8'd0);

      // Overrun: 80, then shutter+80, then 80 -> 240>>2 = 60, err
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd80);
      cyc(1'b1, 1'b1, 8'd80);
      cyc(1'b0, 1'b1, 8'd80);
      exp_fc = exp_fc + 8'd1;
      chk("ovr_rv",     32'(result_valid), 32'd1);
      chk("ovr_result", 32'(result),       32'd60);
      chk("ovr_err",    32'(frame_err),    32'd1);
      chk("ovr_count",  32'(frame_count),  32'(exp_fc));
      cyc(1'b0, 1'b0, 8'd0);

      // Clean frame after overrun clears err: (4+8+12+16)>>2 = 10
      frame("clean", 8'd4, 8'd8, 8'd12, 8'd16, 8'd10, 1'b1);

      // Shutter during EXP2 flags err without restarting: (8*4)>>2 = 8
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd8);
      cyc(1'b0, 1'b1, 8'd8);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd8);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd8);
      exp_fc = exp_fc + 8'd1;
      chk("exp2sh_result", 32'(result),    32'd8);
      chk("exp2sh_err",    32'(frame_err), 32'd1);
      cyc(1'b0, 1'b0, 8'd0);

      // frame_count wrap 255 -> 0
      while (exp_fc != 8'd255) frame("wrap", 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      chk("count_255", 32'(frame_count), 32'd255);
      frame("wrapped", 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
      chk("count_0", 32'(frame_count), 32'd0);

      // Reset mid-EXP2, asserted between clock edges
      frame("pre_rst", 8'd60, 8'd60, 8'd60, 8'd60, 8'd60, 1'b1);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd90);
      cyc(1'b0, 1'b1, 8'd90);
      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 8'd90);
      shutter   = 1'b0;
      pix_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_skip",   32'(skip),         32'd0);
      chk("mid_rst_rv",     32'(result_valid), 32'd0);
      chk("mid_rst_result", 32'(result),       32'd0);
      chk("mid_rst_err",    32'(frame_err),    32'd0);
      chk("mid_rst_count",  32'(frame_count),  32'd0);
      @(negedge clk);
      reset = 1'b1;
      exp_fc = 8'd0;
      frame("post_rst", 8'd16, 8'd32, 8'd48, 8'd64, 8'd40, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
